// File: rtl/uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Shares a single byte-level uart_tx (TxD_start / TxD_data / TxD_busy
//   handshake) between NUM_REQ packet sources. Ownership is granted
//   round-robin per packet. The grant is held from the first byte of a packet
//   until the byte flagged "last" has left the transmitter. A granted source
//   that holds req low mid-packet for STALL_MAX cycles loses its grant.
//
// Parameters:
//   NUM_REQ     number of requesters (1..8)
//   STALL_MAX   cycles a granted requester may hold req low before abort
//   GAP_CYCLES  idle cycles forced after each packet (gap feature only)
//
// Optional feature (compile-time macro):
//   UART_ARB_GAP_EN  when defined, every completed packet is followed by
//                    GAP_CYCLES cycles with grant=0 and requests ignored.
//                    This gives the receiver a line-idle packet delimiter.
//                    When undefined, packets may follow back to back.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous reset, active-low
//   req        in   [NUM_REQ]    per-requester "byte valid"
//   req_data   in   [8*NUM_REQ]  byte of requester i at [8*i+7:8*i]
//   req_last   in   [NUM_REQ]    presented byte is the last of its packet
//   req_ack    out  [NUM_REQ]    1-cycle pulse: byte of requester i taken
//   grant      out  [NUM_REQ]    one-hot current owner, 0 when idle
//   abort      out  1-cycle pulse: grant dropped by stall timeout
//   tx_start   out  to uart_tx TxD_start
//   tx_data    out  [8] to uart_tx TxD_data
//   tx_busy    in   from uart_tx TxD_busy
//------------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int STALL_MAX  = 1024,
   parameter int GAP_CYCLES = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ack,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   abort,
   output logic                   tx_start,
   output logic [7:0]             tx_data,
   input  logic                   tx_busy
);

   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int STALL_W = $clog2(STALL_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT_BUSY,
      S_WAIT_DONE
`ifdef UART_ARB_GAP_EN
      , S_GAP
`endif
   } state_t;

   state_t               state;
   logic [IDX_W-1:0]     rr;          // index of the most recent owner
   logic [IDX_W-1:0]     grant_idx;   // binary form of grant
   logic                 last_q;      // byte in flight closes the packet
   logic [STALL_W-1:0]   stall_cnt;

`ifdef UART_ARB_GAP_EN
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   logic [GAP_W-1:0]     gap_cnt;
`else
   // GAP_CYCLES has no role without the gap feature; tie it off explicitly.
   logic                 unused_gap_cfg;
   assign unused_gap_cfg = (GAP_CYCLES > 0);
`endif

   //---------------------------------------------------------------------------
   // Round-robin pick: the first set req scanning rr+1, rr+2, ... (mod
   // NUM_REQ). Split into "lowest index above rr" and "lowest index overall";
   // the first wins when present, otherwise the search has wrapped around.
   //---------------------------------------------------------------------------
   logic                 hi_found;
   logic [IDX_W-1:0]     hi_idx;
   logic                 lo_found;
   logic [IDX_W-1:0]     lo_idx;
   logic                 pick_valid;
   logic [IDX_W-1:0]     pick_idx;
   logic [NUM_REQ-1:0]   pick_onehot;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // through the block can leave a value held and infer a latch.
      hi_found    = 1'b0;
      hi_idx      = '0;
      lo_found    = 1'b0;
      lo_idx      = '0;
      pick_onehot = '0;
      // Descending scan so the lowest qualifying index is written last.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            if (IDX_W'(i) > rr) begin
               hi_found = 1'b1;
               hi_idx   = IDX_W'(i);
            end
            lo_found = 1'b1;
            lo_idx   = IDX_W'(i);
         end
      end
      pick_valid = hi_found | lo_found;
      pick_idx   = hi_found ? hi_idx : lo_idx;
      for (int i = 0; i < NUM_REQ; i++) begin
         pick_onehot[i] = pick_valid && (IDX_W'(i) == pick_idx);
      end
   end

   //---------------------------------------------------------------------------
   // Owner's request lines, selected by the one-hot grant. Only the owner is
   // ever looked at, so other requesters may toggle freely.
   //---------------------------------------------------------------------------
   logic                 sel_req;
   logic                 sel_last;
   logic [7:0]           sel_data;

   always_comb begin
      sel_req  = 1'b0;
      sel_last = 1'b0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_req  = req[i];
            sel_last = req_last[i];
            sel_data = req_data[8*i +: 8];
         end
      end
   end

   //---------------------------------------------------------------------------
   // Control FSM with registered outputs.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         rr        <= IDX_W'(NUM_REQ - 1);  // requester 0 gets first priority
         grant_idx <= '0;
         grant     <= '0;
         req_ack   <= '0;
         abort     <= 1'b0;
         tx_start  <= 1'b0;
         tx_data   <= '0;
         last_q    <= 1'b0;
         stall_cnt <= '0;
`ifdef UART_ARB_GAP_EN
         gap_cnt   <= '0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // branch below reads pre-edge values and later defaults cannot race.
         req_ack <= '0;
         abort   <= 1'b0;

         case (state)
            S_IDLE: begin
               if (pick_valid) begin
                  grant     <= pick_onehot;
                  grant_idx <= pick_idx;
                  stall_cnt <= '0;
                  state     <= S_LOAD;
               end
            end

            S_LOAD: begin
               if (sel_req) begin
                  // A present byte never counts as a stall, even while the
                  // transmitter is still busy with a byte from before reset.
                  if (!tx_busy) begin
                     tx_data   <= sel_data;
                     tx_start  <= 1'b1;
                     req_ack   <= grant;
                     last_q    <= sel_last;
                     stall_cnt <= '0;
                     state     <= S_WAIT_BUSY;
                  end
               end else if (stall_cnt == STALL_W'(STALL_MAX - 1)) begin
                  // This is the STALL_MAX-th consecutive cycle without a byte.
                  abort     <= 1'b1;
                  grant     <= '0;
                  rr        <= grant_idx;
                  stall_cnt <= '0;
                  state     <= S_IDLE;
               end else begin
                  stall_cnt <= stall_cnt + STALL_W'(1);
               end
            end

            S_WAIT_BUSY: begin
               // uart_tx always accepts eventually, so there is no timeout.
               if (tx_busy) begin
                  tx_start <= 1'b0;
                  state    <= S_WAIT_DONE;
               end
            end

            S_WAIT_DONE: begin
               if (!tx_busy) begin
                  if (last_q) begin
                     rr    <= grant_idx;
                     grant <= '0;
`ifdef UART_ARB_GAP_EN
                     gap_cnt <= '0;
                     state   <= S_GAP;
`else
                     state   <= S_IDLE;
`endif
                  end else begin
                     state <= S_LOAD;
                  end
               end
            end

`ifdef UART_ARB_GAP_EN
            S_GAP: begin
               // Line stays idle for exactly GAP_CYCLES cycles in this state.
               if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                  state <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
`endif

            default: begin
               grant    <= '0;
               tx_start <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter (NUM_REQ=2, STALL_MAX=16,
// GAP_CYCLES=64). A behavioural uart_tx answers tx_start with a fixed-length
// busy window; two requester drivers replay byte queues and advance on ack.
// Expected bytes (source, value) go into a scoreboard when stimulus is queued
// and are popped as the transmitter model accepts each byte.
//------------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int NUM_REQ    = 2;
   localparam int STALL_MAX  = 16;
   localparam int GAP_CYCLES = 64;
   localparam int BYTE_CYC   = 10;
   localparam int BUDGET     = 2000;

   logic                 clk;
   logic                 rst_n;
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ack;
   logic [NUM_REQ-1:0]   grant;
   logic                 abort;
   logic                 tx_start;
   logic [7:0]           tx_data;
   logic                 tx_busy;

   uart_tx_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .STALL_MAX  (STALL_MAX),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .req_data (req_data),
      .req_last (req_last),
      .req_ack  (req_ack),
      .grant    (grant),
      .abort    (abort),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         src;
      logic [7:0] data;
   } exp_t;

   exp_t       sb[$];
   logic [8:0] q0[$];          // {last, data} per pending byte of requester 0
   logic [8:0] q1[$];
   logic [1:0] grant_log[$];   // each new non-zero grant value
   int         gap_log[$];     // cycles from previous busy fall to each start

   int         n_checks;
   int         n_fail;
   int         cycle;
   int         busy_cnt;
   int         last_fall;
   int         abort_cnt;
   int         ack_cnt[2];
   int         hold_off[2];
   int         stall_src;
   int         stall_len;
   bit         stall_armed;
   bit         stall_wait;
   logic [1:0] prev_grant;
   logic [1:0] abort_grant;

   //---------------------------------------------------------------------------
   // Queue helpers
   //---------------------------------------------------------------------------
   function automatic int q_size(int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic [8:0] q_front(int i);
      if (i == 0) return q0[0];
      return q1[0];
   endfunction

   task automatic q_pop(int i);
      if (i == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
   endtask

   task automatic q_clear(int i);
      if (i == 0) q0.delete();
      else        q1.delete();
   endtask

   task automatic add_byte(int i, logic [7:0] d, bit last);
      if (i == 0) q0.push_back({last, d});
      else        q1.push_back({last, d});
   endtask

   task automatic expect_byte(int i, logic [7:0] d);
      exp_t e;
      e.src  = i;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < NUM_REQ; i++) begin
         logic [8:0] f;
         bit         on;
         on = (q_size(i) > 0) && (hold_off[i] == 0) && !(stall_wait && stall_src == i);
         f  = on ? q_front(i) : 9'h000;
         req[i]             = on;
         req_last[i]        = f[8];
         req_data[8*i +: 8] = f[7:0];
      end
   endtask

   //---------------------------------------------------------------------------
   // One clock: sample just after the edge, run the uart_tx model and the
   // requester drivers, compare accepted bytes against the scoreboard.
   //---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
      cycle++;
      for (int i = 0; i < NUM_REQ; i++) if (hold_off[i] > 0) hold_off[i]--;

      if (grant !== prev_grant && grant !== 2'b00) grant_log.push_back(grant);
      prev_grant = grant;

      if (abort === 1'b1) begin
         abort_cnt++;
         abort_grant = grant;
         // The aborted requester abandons the rest of its packet.
         if (stall_src >= 0) begin
            q_clear(stall_src);
            hold_off[stall_src] = 0;
         end
         stall_wait  = 1'b0;
         stall_armed = 1'b0;
      end

      if (tx_busy) begin
         busy_cnt--;
         if (busy_cnt == 0) begin
            tx_busy   = 1'b0;
            last_fall = cycle;
            if (stall_wait) begin
               stall_wait          = 1'b0;
               hold_off[stall_src] = stall_len + 1;
            end
         end
      end else if (tx_start === 1'b1) begin
         int   src;
         exp_t e;
         src = (grant === 2'b01) ? 0 : (grant === 2'b10) ? 1 : -1;
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL tx_byte: got %02h from src %0d, expected no byte", tx_data, src);
         end else begin
            e = sb.pop_front();
            if (src != e.src || tx_data !== e.data) begin
               n_fail++;
               $display("FAIL tx_byte: got %02h from src %0d, expected %02h from src %0d",
                        tx_data, src, e.data, e.src);
            end
         end
         gap_log.push_back(cycle - last_fall);
         tx_busy  = 1'b1;
         busy_cnt = BYTE_CYC;
      end

      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ack[i] === 1'b1) begin
            ack_cnt[i]++;
            n_checks++;
            if (q_size(i) == 0) begin
               n_fail++;
               $display("FAIL ack_src%0d: ack with no byte presented, expected no ack", i);
            end else begin
               q_pop(i);
            end
            if (stall_armed && stall_src == i) begin
               stall_armed = 1'b0;
               stall_wait  = 1'b1;
            end
         end
      end

      drive_reqs();
   endtask

   task automatic wait_idle(string name);
      int n;
      n = 0;
      while (!(q0.size() == 0 && q1.size() == 0 && tx_busy == 1'b0 &&
               grant === 2'b00 && tx_start === 1'b0) && n < BUDGET) begin
         tick();
         n++;
      end
      n_checks++;
      if (n >= BUDGET) begin
         n_fail++;
         $display("FAIL %s_idle: still busy after %0d cycles, expected idle", name, BUDGET);
      end
      repeat (3) tick();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s_sb: %0d bytes never sent, expected 0", name, sb.size());
      end
   endtask

   //---------------------------------------------------------------------------
   // Tests
   //---------------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0;
      add_byte(0, 8'h74, 1'b0); expect_byte(0, 8'h74);
      add_byte(0, 8'h69, 1'b0); expect_byte(0, 8'h69);
      add_byte(0, 8'h72, 1'b1); expect_byte(0, 8'h72);
      add_byte(1, 8'h31, 1'b0); expect_byte(1, 8'h31);
      add_byte(1, 8'h32, 1'b1); expect_byte(1, 8'h32);
      tick();
      tick();
      n_checks += 5;
      if (grant !== 2'b00)   begin n_fail++; $display("FAIL rst_grant: got %b, expected 00", grant); end
      if (req_ack !== 2'b00) begin n_fail++; $display("FAIL rst_ack: got %b, expected 00", req_ack); end
      if (abort !== 1'b0)    begin n_fail++; $display("FAIL rst_abort: got %b, expected 0", abort); end
      if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_tx_start: got %b, expected 0", tx_start); end
      if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %02h, expected 00", tx_data); end
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (grant !== 2'b01) begin n_fail++; $display("FAIL rst_first_grant: got %b, expected 01", grant); end
      wait_idle("reset");
   endtask

   task automatic test_alternate();
      grant_log.delete();
      for (int k = 0; k < 4; k++) begin
         add_byte(0, 8'hA0 + 8'(k), 1'b1);
         add_byte(1, 8'hB0 + 8'(k), 1'b1);
         expect_byte(0, 8'hA0 + 8'(k));
         expect_byte(1, 8'hB0 + 8'(k));
      end
      wait_idle("alternate");
      for (int k = 0; k < 8; k++) begin
         logic [1:0] want;
         want = (k % 2 == 0) ? 2'b01 : 2'b10;
         n_checks++;
         if (k >= grant_log.size()) begin
            n_fail++;
            $display("FAIL alt_grant%0d: got no grant, expected %b", k, want);
         end else if (grant_log[k] !== want) begin
            n_fail++;
            $display("FAIL alt_grant%0d: got %b, expected %b", k, grant_log[k], want);
         end
      end
   endtask

   task automatic test_stall_abort();
      int a0;
      int k1;
      int n;
      a0          = abort_cnt;
      k1          = ack_cnt[1];
      abort_grant = 2'b11;
      grant_log.delete();
      stall_src   = 1;
      stall_len   = STALL_MAX;
      stall_armed = 1'b1;
      add_byte(1, 8'hC0, 1'b0); expect_byte(1, 8'hC0);
      add_byte(1, 8'hC1, 1'b0);
      add_byte(1, 8'hC2, 1'b0);
      add_byte(1, 8'hC3, 1'b1);
      n = 0;
      while (grant !== 2'b10 && n < BUDGET) begin
         tick();
         n++;
      end
      n_checks++;
      if (n >= BUDGET) begin
         n_fail++;
         $display("FAIL abort_grant1: got %b, expected 10", grant);
      end
      add_byte(0, 8'hD0, 1'b0); expect_byte(0, 8'hD0);
      add_byte(0, 8'hD1, 1'b1); expect_byte(0, 8'hD1);
      wait_idle("abort");
      n_checks += 4;
      if (abort_cnt - a0 != 1) begin
         n_fail++;
         $display("FAIL abort_count: got %0d pulses, expected 1", abort_cnt - a0);
      end
      if (abort_grant !== 2'b00) begin
         n_fail++;
         $display("FAIL abort_grant_drop: got %b with abort, expected 00", abort_grant);
      end
      if (grant_log.size() < 2 || grant_log[1] !== 2'b01) begin
         n_fail++;
         $display("FAIL abort_next_grant: got %0d grants (2nd %b), expected 2nd 01",
                  grant_log.size(), (grant_log.size() > 1) ? grant_log[1] : 2'bxx);
      end
      if (ack_cnt[1] - k1 != 1) begin
         n_fail++;
         $display("FAIL abort_acks: got %0d, expected 1", ack_cnt[1] - k1);
      end
   endtask

   task automatic test_stall_resume();
      int a0;
      int k1;
      a0          = abort_cnt;
      k1          = ack_cnt[1];
      stall_src   = 1;
      stall_len   = STALL_MAX - 1;
      stall_armed = 1'b1;
      add_byte(1, 8'hE0, 1'b0); expect_byte(1, 8'hE0);
      add_byte(1, 8'hE1, 1'b0); expect_byte(1, 8'hE1);
      add_byte(1, 8'hE2, 1'b0); expect_byte(1, 8'hE2);
      add_byte(1, 8'hE3, 1'b1); expect_byte(1, 8'hE3);
      wait_idle("resume");
      n_checks += 2;
      if (abort_cnt != a0) begin
         n_fail++;
         $display("FAIL resume_abort: got %0d pulses, expected 0", abort_cnt - a0);
      end
      if (ack_cnt[1] - k1 != 4) begin
         n_fail++;
         $display("FAIL resume_acks: got %0d, expected 4", ack_cnt[1] - k1);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      // A packet from requester 0 first, so the pointer favours requester 1.
      add_byte(0, 8'h5A, 1'b1); expect_byte(0, 8'h5A);
      wait_idle("midrst_pre");
      add_byte(1, 8'hF0, 1'b0); expect_byte(1, 8'hF0);
      add_byte(1, 8'hF1, 1'b1);
      n = 0;
      while (tx_start !== 1'b1 && n < BUDGET) begin
         tick();
         n++;
      end
      n_checks++;
      if (n >= BUDGET) begin
         n_fail++;
         $display("FAIL midrst_start: got no tx_start, expected one");
      end
      grant_log.delete();
      rst_n = 1'b0;
      add_byte(0, 8'h60, 1'b0);
      add_byte(0, 8'h61, 1'b1);
      expect_byte(0, 8'h60);
      expect_byte(0, 8'h61);
      expect_byte(1, 8'hF1);
      tick();
      n_checks += 3;
      if (tx_start !== 1'b0) begin n_fail++; $display("FAIL midrst_tx_start: got %b, expected 0", tx_start); end
      if (grant !== 2'b00)   begin n_fail++; $display("FAIL midrst_grant: got %b, expected 00", grant); end
      if (req_ack !== 2'b00) begin n_fail++; $display("FAIL midrst_ack: got %b, expected 00", req_ack); end
      rst_n = 1'b1;
      wait_idle("midrst");
      n_checks++;
      if (grant_log.size() == 0 || grant_log[0] !== 2'b01) begin
         n_fail++;
         $display("FAIL midrst_first_grant: got %b, expected 01",
                  (grant_log.size() > 0) ? grant_log[0] : 2'bxx);
      end
   endtask

   task automatic test_back_to_back();
      gap_log.delete();
      add_byte(0, 8'h80, 1'b1); expect_byte(0, 8'h80);
      add_byte(0, 8'h81, 1'b1); expect_byte(0, 8'h81);
      wait_idle("b2b");
      n_checks++;
      if (gap_log.size() != 2) begin
         n_fail++;
         $display("FAIL b2b_starts: got %0d, expected 2", gap_log.size());
      end else begin
`ifdef UART_ARB_GAP_EN
         if (gap_log[1] < GAP_CYCLES) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d cycles, expected >= %0d", gap_log[1], GAP_CYCLES);
         end
`else
         if (gap_log[1] > 3 || gap_log[1] < 1) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d cycles, expected 1..3", gap_log[1]);
         end
`endif
      end
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      cycle       = 0;
      busy_cnt    = 0;
      last_fall   = 0;
      abort_cnt   = 0;
      ack_cnt[0]  = 0;
      ack_cnt[1]  = 0;
      hold_off[0] = 0;
      hold_off[1] = 0;
      stall_src   = -1;
      stall_len   = 0;
      stall_armed = 1'b0;
      stall_wait  = 1'b0;
      prev_grant  = 2'b00;
      abort_grant = 2'b11;
      rst_n       = 1'b0;
      tx_busy     = 1'b0;
      req         = '0;
      req_data    = '0;
      req_last    = '0;

      test_reset();
      test_alternate();
      test_stall_abort();
      test_stall_resume();
      test_reset_mid();
      test_back_to_back();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
